reg_bus_master: RTL and testbench

Host-side transaction master for the switch's internal register bus. It accepts one read or write request at a time from the host/configuration port and drives the shared select/address/data bus seen by all per-register decoders. It collects their registered `ack`/`rd_data` returns and hands back a single-cycle response with read data and an error flag. It sits directly upstream of the register decoder array.

---
 rtl/reg_bus_pkg.sv | 22 ++
 rtl/reg_bus_timer.sv | 36 +++
 rtl/reg_bus_master.sv | 122 ++++++++++++
 tb/tb_reg_bus_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_pkg : shared types and constants for the register bus master
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg_bus_pkg;

   localparam int   DEFAULT_W_WIDTH = 8;

   localparam logic BUS_WR = 1'b1;
   localparam logic BUS_RD = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_bus_timer.sv
// ---------------------------------------------------------------------------
// reg_bus_timer : ACCESS-phase watchdog, expires on the TIMEOUT_CYCLES-th idle cycle
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_bus_timer #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // cnt holds the number of earlier idle cycles, so this cycle is the last allowed one
   assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/reg_bus_master.sv
// ---------------------------------------------------------------------------
// reg_bus_master : host-side register bus master (optional timeout: REG_BUS_MASTER_TIMEOUT_EN)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int W_WIDTH        = DEFAULT_W_WIDTH,
   parameter int NUM_REGS       = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_wr,
   input  logic [W_WIDTH-1:0]          req_addr,
   input  logic [W_WIDTH-1:0]          req_wdata,
   output logic                        rsp_valid,
   output logic [W_WIDTH-1:0]          rsp_rdata,
   output logic                        rsp_err,
   output logic                        sel_en,
   output logic                        wr_rd_s,
   output logic [W_WIDTH-1:0]          addr,
   output logic [W_WIDTH-1:0]          wdata,
   input  logic [NUM_REGS-1:0]         ack_in,
   input  logic [NUM_REGS*W_WIDTH-1:0] rd_data_in
);

   state_t             state;
   logic [W_WIDTH-1:0] rd_or;
   logic               any_ack;
   logic               multi_ack;
   logic               accept;
   logic               tmo_expired;

   // Decoders drive zero when not addressed, so the OR is the selected decoder's data
   always_comb begin
      rd_or = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_or = rd_or | rd_data_in[i*W_WIDTH +: W_WIDTH];
      end
   end

   assign any_ack   = |ack_in;
   assign multi_ack = |(ack_in & (ack_in - NUM_REGS'(1)));
   assign accept    = (state == IDLE) && req_valid && req_ready;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
   logic tmo_en;

   assign tmo_en = (state == ACCESS) && !any_ack;

   reg_bus_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .en      (tmo_en),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         sel_en    <= 1'b0;
         wr_rd_s   <= BUS_RD;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  sel_en    <= 1'b1;
                  wr_rd_s   <= req_wr ? BUS_WR : BUS_RD;
                  addr      <= req_addr;
                  wdata     <= req_wdata;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (any_ack || tmo_expired) begin
                  sel_en    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RELEASE;
                  if (any_ack && !multi_ack) begin
                     rsp_err   <= 1'b0;
                     rsp_rdata <= (wr_rd_s == BUS_WR) ? '0 : rd_or;
                  end else begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            RELEASE: begin
               // Wait for every decoder to drop ack so a stale ack cannot hit the next access
               if (!any_ack) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master : directed self-checking bench for reg_bus_master
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_bus_master;

   localparam int W  = 8;
   localparam int NR = 4;
   localparam int TC = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [W-1:0]  req_addr = '0;
   logic [W-1:0]  req_wdata = '0;
   logic          rsp_valid;
   logic [W-1:0]  rsp_rdata;
   logic          rsp_err;
   logic          sel_en;
   logic          wr_rd_s;
   logic [W-1:0]  addr;
   logic [W-1:0]  wdata;
   logic [NR-1:0] ack_in = '0;
   logic [NR*W-1:0] rd_data_in = '0;

   // decoder model controls
   logic [NR-1:0] resp_mask = '0;
   logic [NR-1:0] hold_mask = '0;
   logic [W-1:0]  dec_data [NR];

   int n_checks = 0;
   int n_errors = 0;

   reg_bus_master #(
      .W_WIDTH        (W),
      .NUM_REGS       (NR),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .sel_en     (sel_en),
      .wr_rd_s    (wr_rd_s),
      .addr       (addr),
      .wdata      (wdata),
      .ack_in     (ack_in),
      .rd_data_in (rd_data_in)
   );

   always #5 clk = ~clk;

   // registered decoders: ack one cycle after seeing sel_en, data only on reads
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) begin
         ack_in[i] <= (sel_en & resp_mask[i]) | hold_mask[i];
         rd_data_in[i*W +: W] <= (sel_en && resp_mask[i] && !wr_rd_s) ? dec_data[i] : '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns #1 after the accept edge
   task automatic issue(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int budget, output int lat, output logic err,
                           output logic [W-1:0] data);
      lat  = 0;
      err  = 1'b0;
      data = '0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat  = k;
            err  = rsp_err;
            data = rsp_rdata;
            break;
         end
      end
   endtask

   int          lat;
   logic        err;
   logic [W-1:0] data;
   int          acc_t [3];
   int          acc, nrsp, bad;
   logic        seen;

   initial begin
      dec_data[0] = 8'h11;
      dec_data[1] = 8'h22;
      dec_data[2] = 8'h3C;
      dec_data[3] = 8'h44;

      // reset state
      #2;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_sel_en",    {31'd0, sel_en},    32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_bus",       {15'd0, wr_rd_s, addr, wdata}, 32'd0);
      check("rst_rsp",       {23'd0, rsp_err, rsp_rdata}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);

      // write 0x05 / 0xA5, decoder 1 acks
      resp_mask = 4'b0010;
      issue(1'b1, 8'h05, 8'hA5);
      @(negedge clk);
      check("wr_c1_bus", {14'd0, sel_en, wr_rd_s, addr, wdata}, {14'd0, 2'b11, 8'h05, 8'hA5});
      check("wr_c1_ready", {30'd0, req_ready, rsp_valid}, 32'd0);
      @(negedge clk);
      check("wr_c2_bus", {14'd0, sel_en, wr_rd_s, addr, wdata}, {14'd0, 2'b11, 8'h05, 8'hA5});
      check("wr_c2_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("wr_c3_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata, 1'b0, sel_en}, {22'd0, 2'b10, 8'h00, 2'b00});
      @(negedge clk);
      check("wr_c4_pulse", {30'd0, rsp_valid, req_ready}, 32'd0);
      check("wr_c4_hold",  {15'd0, wr_rd_s, addr, wdata}, {15'd0, 1'b1, 8'h05, 8'hA5});
      @(negedge clk);
      check("wr_c5_ready", {31'd0, req_ready}, 32'd1);

      // read 0x02, decoder 2 returns 0x3C
      resp_mask = 4'b0100;
      issue(1'b0, 8'h02, 8'h00);
      wait_rsp(10, lat, err, data);
      check("rd_lat",  lat, 32'd3);
      check("rd_rsp",  {23'd0, err, data}, {23'd0, 1'b0, 8'h3C});

      // two decoders ack together
      resp_mask = 4'b0011;
      issue(1'b0, 8'h01, 8'h00);
      wait_rsp(10, lat, err, data);
      check("multi_lat", lat, 32'd3);
      check("multi_rsp", {23'd0, err, data}, {23'd0, 1'b1, 8'h00});

      // back-to-back with req_valid held high
      resp_mask = 4'b0001;
      req_wr    = 1'b0;
      req_addr  = 8'h00;
      req_valid = 1'b1;
      acc = 0; nrsp = 0; bad = 0;
      for (int k = 0; k < 40 && acc < 3; k++) begin
         @(negedge clk);
         if (sel_en && req_ready) bad++;
         if (rsp_valid) nrsp++;
         if (req_ready) begin
            acc_t[acc] = k;
            acc++;
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(10, lat, err, data);
      if (lat == 3) nrsp++;
      check("b2b_accepts", acc, 32'd3);
      check("b2b_gap1", acc_t[1] - acc_t[0], 32'd5);
      check("b2b_gap2", acc_t[2] - acc_t[1], 32'd5);
      check("b2b_ready_in_access", bad, 32'd0);
      check("b2b_rsps", nrsp, 32'd3);

      // RELEASE extended by a held ack
      resp_mask = 4'b0001;
      issue(1'b0, 8'h00, 8'h00);
      wait_rsp(10, lat, err, data);
      check("ext_lat", lat, 32'd3);
      hold_mask = 4'b0001;
      @(negedge clk);
      check("ext_c4_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      hold_mask = 4'b0000;
      @(negedge clk);
      check("ext_c7", {30'd0, req_ready, rsp_valid}, 32'd0);
      @(negedge clk);
      check("ext_c8_ready", {31'd0, req_ready}, 32'd1);

      // no decoder answers
      resp_mask = 4'b0000;
      issue(1'b0, 8'h07, 8'h00);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
      wait_rsp(40, lat, err, data);
      check("tmo_lat", lat, TC + 1);
      check("tmo_rsp", {23'd0, err, data}, {23'd0, 1'b1, 8'h00});
      @(negedge clk);
      check("tmo_sel_low", {31'd0, sel_en}, 32'd0);
`else
      wait_rsp(100, lat, err, data);
      check("notmo_no_rsp", lat, 32'd0);
      check("notmo_sel_held", {31'd0, sel_en}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif

      // reset in the second ACCESS cycle
      resp_mask   = 4'b0100;
      dec_data[2] = 8'h5A;
      issue(1'b0, 8'h02, 8'h00);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_sel_low", {30'd0, sel_en, req_ready}, 32'd0);
      seen = rsp_valid;
      repeat (3) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      check("mrst_no_rsp", {31'd0, seen}, 32'd0);
      issue(1'b0, 8'h02, 8'h00);
      wait_rsp(10, lat, err, data);
      check("mrst_rd_lat", lat, 32'd3);
      check("mrst_rd_rsp", {23'd0, err, data}, {23'd0, 1'b0, 8'h5A});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
